// File: rtl/star_box_drawer.sv
// star_box_drawer: walks a latched box in raster order plotting its outline, or every pixel when STAR_BOX_FILL_EN is defined
module star_box_drawer #(
  parameter int XSZ = 3,
  parameter int YSZ = 3,
  parameter int COL_SZ = 3,
  parameter logic [COL_SZ-1:0] BOX_COLOUR = 3'b100
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              goDraw,
  input  logic [XSZ-1:0]    left,
  input  logic [XSZ-1:0]    right,
  input  logic [YSZ-1:0]    top,
  input  logic [YSZ-1:0]    bottom,
  output logic [XSZ-1:0]    xOut,
  output logic [YSZ-1:0]    yOut,
  output logic [COL_SZ-1:0] colour,
  output logic              plotEn,
  output logic              doneDraw,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE, WAIT_RELEASE} state_t;
  state_t state_q, state_d;
  logic [XSZ-1:0] x_q, x_d, l_q, l_d, r_q, r_d;
  logic [YSZ-1:0] y_q, y_d, t_q, t_d, b_q, b_d;
  logic [COL_SZ-1:0] colour_q, colour_d;
  logic plot_q, plot_d, done_q, done_d, busy_q, busy_d, on_box;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    l_d = l_q;
    r_d = r_q;
    t_d = t_q;
    b_d = b_q;
    case (state_q)
      IDLE: if (goDraw) begin
        l_d = left;
        r_d = right;
        t_d = top;
        b_d = bottom;
        x_d = left;
        y_d = top;
        state_d = (left > right || top > bottom) ? DONE : SCAN;
      end
      SCAN: if (!goDraw) state_d = IDLE;
        else if (x_q != r_q) x_d = x_q + XSZ'(1);
        else if (y_q != b_q) begin
          x_d = l_q;
          y_d = y_q + YSZ'(1);
        end
        else state_d = DONE;
      DONE: state_d = WAIT_RELEASE;
      default: state_d = goDraw ? WAIT_RELEASE : IDLE;
    endcase
`ifdef STAR_BOX_FILL_EN
    on_box = 1'b1;
`else
    on_box = x_d == l_d || x_d == r_d || y_d == t_d || y_d == b_d;
`endif
    plot_d = state_d == SCAN && on_box;
    colour_d = plot_d ? BOX_COLOUR : '0;
    done_d = state_d == DONE;
    busy_d = state_d == SCAN || state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      l_q <= '0;
      r_q <= '0;
      t_q <= '0;
      b_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      l_q <= l_d;
      r_q <= r_d;
      t_q <= t_d;
      b_q <= b_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign xOut = x_q;
  assign yOut = y_q;
  assign colour = colour_q;
  assign plotEn = plot_q;
  assign doneDraw = done_q;
  assign busy = busy_q;
endmodule
